// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift/add multiplier.
package mult_pkg;

  localparam int MULT_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM for seq_mult_unit: sequences IDLE -> CALC -> DONE and the result handshake.
module seq_mult_ctrl
  import mult_pkg::*;
(
  input  logic SYS_CLOCK,
  input  logic SYS_RESET,
  input  logic start,
  input  logic f_ack,
  input  logic calc_last,
  output logic ready,
  output logic f_valid,
  output logic accept,
  output logic finish
);

  mult_state_t state, state_nxt;

  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_RESET) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)     state_nxt = CALC;
      CALC:    if (calc_last) state_nxt = DONE;
      DONE:    if (f_ack)     state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready   = (state == IDLE);
    f_valid = (state == DONE);
    accept  = (state == IDLE) && start;
    finish  = (state == CALC) && calc_last;
  end

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential unsigned shift/add multiplier, one multiplier bit per cycle.
// Optional early termination when the remaining multiplier is zero: define MULT_EARLY_TERM_EN.
module seq_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_DEFAULT_WIDTH
) (
  input  logic               SYS_CLOCK,
  input  logic               SYS_RESET,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               READY,
  output logic [2*WIDTH-1:0] F_REG,
  output logic               F_VALID,
  input  logic               F_ACK
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               accept, finish, calc_last, step, in_calc;

  // The exit decision looks at registered state, so the last CALC cycle only
  // transfers the finished accumulator into F_REG.
`ifdef MULT_EARLY_TERM_EN
  assign calc_last = (cnt == CNT_MAX) || ((cnt != '0) && (mplier == '0));
`else
  assign calc_last = (cnt == CNT_MAX);
`endif

  seq_mult_ctrl u_ctrl (
    .SYS_CLOCK (SYS_CLOCK),
    .SYS_RESET (SYS_RESET),
    .start     (START),
    .f_ack     (F_ACK),
    .calc_last (calc_last),
    .ready     (READY),
    .f_valid   (F_VALID),
    .accept    (accept),
    .finish    (finish)
  );

  // In CALC and not finishing; counter saturates at WIDTH by construction.
  assign in_calc = !READY && !F_VALID;
  assign step    = in_calc && !calc_last;

  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_RESET) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_RESET)   F_REG <= '0;
    else if (finish) F_REG <= acc;
  end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed scoreboard bench for seq_mult_unit at WIDTH=8 (latency follows MULT_EARLY_TERM_EN).
module tb_seq_mult_unit;

  logic        SYS_CLOCK = 1'b0;
  logic        SYS_RESET = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic        READY;
  logic [15:0] F_REG;
  logic        F_VALID;
  logic        F_ACK = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 SYS_CLOCK = ~SYS_CLOCK;

  seq_mult_unit #(.WIDTH(8)) dut (
    .SYS_CLOCK (SYS_CLOCK),
    .SYS_RESET (SYS_RESET),
    .START     (START),
    .A         (A),
    .B         (B),
    .READY     (READY),
    .F_REG     (F_REG),
    .F_VALID   (F_VALID),
    .F_ACK     (F_ACK)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

`ifdef MULT_EARLY_TERM_EN
  function automatic int exp_lat(input logic [7:0] b);
    int h;
    h = -1;
    for (int i = 0; i < 8; i++) if (b[i]) h = i;
    return (h < 0) ? 2 : h + 2;
  endfunction
`else
  function automatic int exp_lat(input logic [7:0] b);
    return (b === 8'hxx) ? 0 : 9;
  endfunction
`endif

  // Accept (a,b) at the next edge, wait for F_VALID, check, hold ack_dly cycles, then ack.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input int ack_dly, input bit poke);
    int t;
    int lat;
    logic [15:0] e;
    t = 0;
    while (READY !== 1'b1 && t < 50) begin @(negedge SYS_CLOCK); t++; end
    chk("ready_before_start", {31'd0, READY}, 32'd1);
    START = 1'b1; A = a; B = b;
    exp_q.push_back(16'(a) * 16'(b));
    @(negedge SYS_CLOCK);
    START = 1'b0; A = 8'($urandom); B = 8'($urandom);
    lat = 0;
    chk("ready_low_in_calc", {31'd0, READY}, 32'd0);
    while (F_VALID !== 1'b1 && lat < 40) begin
      if (poke && lat == 1) begin START = 1'b1; A = 8'd9; B = 8'd9; F_ACK = 1'b1; end
      @(negedge SYS_CLOCK);
      START = 1'b0; F_ACK = 1'b0;
      lat++;
    end
    chk("latency", lat, exp_lat(b));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk("product", {16'd0, F_REG}, {16'd0, e});
    for (int i = 0; i < ack_dly; i++) begin
      if (poke) begin START = 1'b1; A = 8'd1; B = 8'd1; end
      @(negedge SYS_CLOCK);
      START = 1'b0;
      chk("hold_freg", {16'd0, F_REG}, {16'd0, e});
      chk("hold_fvalid", {31'd0, F_VALID}, 32'd1);
      chk("hold_ready", {31'd0, READY}, 32'd0);
    end
    F_ACK = 1'b1;
    @(negedge SYS_CLOCK);
    F_ACK = 1'b0;
    chk("ready_after_ack", {31'd0, READY}, 32'd1);
    chk("fvalid_after_ack", {31'd0, F_VALID}, 32'd0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge SYS_CLOCK);
    SYS_RESET = 1'b0;
    chk("reset_ready", {31'd0, READY}, 32'd1);
    chk("reset_fvalid", {31'd0, F_VALID}, 32'd0);
    chk("reset_freg", {16'd0, F_REG}, 32'd0);

    // F_ACK while idle must do nothing
    F_ACK = 1'b1;
    @(negedge SYS_CLOCK);
    F_ACK = 1'b0;
    chk("idle_ack_ignored", {31'd0, READY}, 32'd1);

    run(8'd13, 8'd11, 5, 1'b0);
    run(8'd255, 8'd255, 0, 1'b0);
    run(8'd3, 8'd4, 2, 1'b1);

    // Abort an operation with reset sampled at edge 4
    START = 1'b1; A = 8'd20; B = 8'd30;
    @(negedge SYS_CLOCK);
    START = 1'b0;
    repeat (3) @(negedge SYS_CLOCK);
    SYS_RESET = 1'b1;
    @(negedge SYS_CLOCK);
    SYS_RESET = 1'b0;
    chk("abort_ready", {31'd0, READY}, 32'd1);
    chk("abort_freg", {16'd0, F_REG}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (F_VALID !== 1'b0) seen = 1'b1;
      @(negedge SYS_CLOCK);
    end
    chk("abort_no_fvalid", {31'd0, seen}, 32'd0);
    run(8'd2, 8'd5, 0, 1'b0);

    run(8'd7, 8'd1, 0, 1'b0);
    run(8'd5, 8'd0, 0, 1'b0);
    run(8'd6, 8'd7, 0, 1'b0);
    run(8'd200, 8'd128, 1, 1'b0);
    for (int i = 0; i < 4; i++) run(8'($urandom), 8'($urandom), i, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_unit.md
SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 8, giving the operand width (legal range 2..16).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port SYS_CLOCK  input  1  system clock; all state updates on the rising edge.
REQ-004 Port SYS_RESET  input  1  synchronous active-high reset.
REQ-005 Port START  input  1  request to multiply; accepted only when READY=1.
REQ-006 Port A  input  WIDTH  unsigned multiplicand; sampled on accept.
REQ-007 Port B  input  WIDTH  unsigned multiplier; sampled on accept.
REQ-008 Port READY  output  1  block is idle and can accept START.
REQ-009 Port F_REG  output  2*WIDTH  product register.
REQ-010 Port F_VALID  output  1  F_REG holds a completed product.
REQ-011 Port F_ACK  input  1  consumer has taken F_REG.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-013 READY SHALL be 1 only in IDLE; F_VALID SHALL be 1 only in DONE.
REQ-014 IDLE, START=1: on that edge the block SHALL latch A and B, clear the 2*WIDTH accumulator and the iteration counter, and enter CALC.
REQ-015 CALC, each cycle: if multiplier LSB=1, accumulator += shifted multiplicand (2*WIDTH-bit add, no truncation); multiplicand <<1; multiplier >>1; counter +1.
REQ-016 CALC SHALL exit to DONE on the edge where the counter reaches WIDTH; on the same edge F_REG SHALL load the final product.
REQ-017 Latency: accept at edge 0 SHALL give F_VALID=1 after edge WIDTH+1 (macro off).
REQ-018 DONE: F_REG and F_VALID SHALL hold until F_ACK=1; F_ACK=1 in DONE SHALL return the FSM to IDLE on the next edge.
REQ-019 START outside IDLE SHALL be ignored, with no effect on operands or result.
REQ-020 F_ACK outside DONE SHALL be ignored.
REQ-021 The earliest next accept SHALL be the cycle after F_ACK; START and F_ACK are not combined in one cycle.
REQ-022 The counter SHALL be $clog2(WIDTH+1) bits and SHALL NOT wrap.

Reset
REQ-023 SYS_RESET=1 at an edge SHALL force IDLE, F_REG=0, F_VALID=0, and clear the accumulator, counter and operand registers.
REQ-024 Reset SHALL take precedence over START and F_ACK.
REQ-025 Reset mid-CALC SHALL abort the operation; F_VALID SHALL NOT rise for the aborted operation.
REQ-026 READY SHALL be 1 in the first cycle after the reset edge.

Configuration
REQ-027 The macro MULT_EARLY_TERM_EN SHALL control early termination.
REQ-028 With MULT_EARLY_TERM_EN defined, CALC SHALL also exit to DONE when the post-shift multiplier equals 0.
  - CALC always lasts at least 1 cycle.
  - F_REG SHALL equal the full product.
  - Latency SHALL be (index of the highest set bit of B)+2 edges; B=0 gives 2.
REQ-029 Without the macro, latency SHALL always be WIDTH+1 edges.

Structure
REQ-030 Package mult_pkg SHALL hold typedef mult_state_t (IDLE, CALC, DONE) and the constant MULT_DEFAULT_WIDTH=8.
REQ-031 The FSM SHALL live in a sub-module seq_mult_ctrl; the shift/add registers SHALL stay in seq_mult_unit.

Verification (WIDTH=8)
REQ-032 Basic multiply: A=13, B=11, START at edge 0 -> F_VALID=1 after edge 9 with F_REG=143; F_REG holds through a 5-cycle F_ACK delay with READY=0.
REQ-033 Maximum operands: A=255, B=255 -> F_REG=65025; no truncation.
REQ-034 START while busy: accept A=3, B=4, then assert START with A=9, B=9 during CALC -> F_REG=12; the second request is not accepted.
REQ-035 Reset mid-CALC: SYS_RESET at edge 4 -> F_VALID never rises, F_REG=0, READY=1 on the next cycle; a new accept of A=2, B=5 then gives F_REG=10.
REQ-036 Early termination:
  - Macro on: A=7, B=1 -> F_VALID after edge 2, F_REG=7; A=5, B=0 -> after edge 2, F_REG=0.
  - Macro off: both cases complete after edge 9.
REQ-037 Back-to-back: F_ACK at cycle n, START at cycle n+1 with A=6, B=7 -> accepted, F_REG=42.
